cti_counter_updater: RTL and testbench
======================================

# cti_counter_updater

- Read-modify-write engine that owns every update to the CTI counter RAM in the fetch stage.
- Accepts a bundle of up to WPORT counter operations per cycle from fetch/commit logic and queues them.
- Drains one operation per cycle through the counter RAM's single combinational read port and writes the result back on write port 0.
- Is the sole writer of that RAM and forwards its own in-flight write, so back-to-back updates to one index never lose an increment.

## Interface
Parameters:
- WPORT, `FETCH_WIDTH: request lanes per bundle.
- DEPTH, 16: counter RAM entries.
- INDEX, 4: counter index width, log2(DEPTH).
- WIDTH, 8: counter width.
- QDEPTH, 8: request queue entries; power of 2, must be >= WPORT.

Ports:
- Clocking: clk and reset are already decided; reset is synchronous, active-high; clock is clk.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  WPORT  per-lane request valid.
- req_index_i  in  WPORT*INDEX  per-lane counter index; lane n occupies bits [n*INDEX +: INDEX].
- req_op_i  in  WPORT*2  per-lane cti_op_t.
- req_ready_o  out  1  bundle accepted this cycle when high.
- flush_i  in  1  discard all queued and unissued requests.
- ram_rd_addr_o  out  INDEX  counter RAM read address.
- ram_rd_data_i  in  WIDTH  counter RAM read data; combinational, same cycle as the address.
- ram_wr_addr_o  out  INDEX  write address to RAM port 0.
- ram_wr_data_o  out  WIDTH  write data to RAM port 0.
- ram_we_o  out  1  write enable to RAM port 0.
- sat_o  out  1  one-cycle pulse: the op being written saturated.
- count_o  out  log2(QDEPTH)+1  queue occupancy.
- busy_o  out  1  queue non-empty or write stage valid.

## Operation
- Ops (cti_op_t): CTI_INC gives min(v+1, 2^WIDTH-1). CTI_DEC gives max(v-1, 0). CTI_CLR gives 0. CTI_NOP is never enqueued.
- Enqueue:
  - req_ready_o = (QDEPTH - count) >= WPORT, computed from registered occupancy.
  - When req_ready_o is high, lanes with valid set and op != NOP are compacted and pushed in ascending lane order in that cycle.
  - Zero such lanes pushes nothing.
  - When req_ready_o is low, the bundle is not taken; the requester holds it.
- Pipeline:
  - Stage 1 (read/compute): pops the queue head, drives ram_rd_addr_o = head index, takes operand v, computes the result, and registers it into stage 2.
  - Stage 2 (write): drives ram_we_o=1 with the registered address and data.
- Forwarding: when stage 2 is valid and its address equals the stage 1 address, v = stage-2 data instead of ram_rd_data_i.
- sat_o asserts in the stage-2 cycle when the op was INC at max or DEC at 0. The unchanged value is still written.
- Simultaneous push and pop: both happen; count changes by pushed-1.
- Flush:
  - Empties the queue and cancels that cycle's stage-1 pop; no stage-2 entry is created the next cycle.
  - An already-valid stage-2 write completes.
  - A bundle presented in the flush cycle is discarded even when req_ready_o is high.
- Reset (also mid-operation): queue empty, stage 2 invalid, no write issued in the following cycle.
- Reset values:
  - req_ready_o=1.
  - ram_we_o=0, sat_o=0, busy_o=0, count_o=0.
  - ram_rd_addr_o=0, ram_wr_addr_o=0, ram_wr_data_o=0.
- Idle read address: when the queue is empty, ram_rd_addr_o holds its last value.
- Pointers wrap modulo QDEPTH. Full and empty are distinguished by count, not by pointer equality.

## Timing
- Bundle accepted in cycle t: earliest read t+1, ram_we_o t+2, RAM value visible to other readers t+3.
- Sustained throughput: one update per cycle, with no bubble for same-index back-to-back ops (forwarding covers the 1-cycle gap).
- A full queue drains in QDEPTH cycles plus 1 for the final write.
- req_ready_o and count_o update the cycle after a push or pop. There is no combinational path from req_valid_i to req_ready_o.

## Structure
- Package cti_pkg:
  - typedef enum logic [1:0] cti_op_t {CTI_INC=0, CTI_DEC=1, CTI_CLR=2, CTI_NOP=3}.
  - struct cti_req_t {index, op}.
  - Saturation-limit constant.
- Sub-module cti_req_fifo: WPORT-push / 1-pop compacting circular FIFO with flush, count and ready.
- The top level holds stage 1, stage 2, forwarding and saturation detect.

## Test plan
- Reset then INC to index 3 on lane 0 at t: ram_we_o at t+2, addr 3, data 1; sat_o=0; busy_o low at t+3.
- Full bundle of WPORT INCs all to index 5 (RAM starts 0): WPORT consecutive writes 1,2,…,WPORT to index 5 via forwarding; no lost increments.
- Index 7 preloaded 255 (WIDTH=8), INC: writes 255, sat_o pulses. Index 2 at 0, DEC: writes 0, sat_o pulses.
- Fill to QDEPTH: req_ready_o drops when count > QDEPTH-WPORT and rises after enough pops. The held bundle is accepted exactly once.
- flush_i with 6 queued and a stage-2 write valid: that write completes; count_o=0 next cycle; no further ram_we_o; a same-cycle bundle is dropped.
- reset asserted mid-drain: the next cycle has ram_we_o=0 and count_o=0, and req_ready_o=1.

Source files
------------

// File: rtl/cti_pkg.sv
// rtl/cti_pkg.sv - shared op encoding, request type and limits for the CTI counter updater
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package cti_pkg;

    localparam int CTI_FETCH_WIDTH = `FETCH_WIDTH;
    localparam int CTI_INDEX       = 4;
    localparam int CTI_WIDTH       = 8;

    // Saturation ceiling for the default counter width; the top derives its own for other widths.
    localparam logic [CTI_WIDTH-1:0] CTI_SAT_MAX = '1;

    typedef enum logic [1:0] {
        CTI_INC = 2'd0,
        CTI_DEC = 2'd1,
        CTI_CLR = 2'd2,
        CTI_NOP = 2'd3
    } cti_op_t;

    typedef struct packed {
        logic [CTI_INDEX-1:0] index;
        cti_op_t              op;
    } cti_req_t;

endpackage

// File: rtl/cti_req_fifo.sv
// rtl/cti_req_fifo.sv - WPORT-push / 1-pop compacting circular request queue with flush
module cti_req_fifo
    import cti_pkg::*;
#(
    parameter int WPORT  = CTI_FETCH_WIDTH,
    parameter int INDEX  = CTI_INDEX,
    parameter int QDEPTH = 8,
    localparam int PW    = $clog2(QDEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WPORT-1:0]       push_valid_i,
    input  logic [WPORT*INDEX-1:0] push_index_i,
    input  logic [WPORT*2-1:0]     push_op_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [INDEX-1:0]       head_index_o,
    output logic [1:0]             head_op_o,
    output logic                   empty_o,
    output logic                   ready_o,
    output logic [CW-1:0]          count_o
);

    logic [INDEX+1:0] mem_q [QDEPTH];
    logic [INDEX+1:0] mem_d [QDEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    n_push;
    logic [PW-1:0]    slot;
    logic             do_pop;

    assign ready_o      = (CW'(QDEPTH) - count_q) >= CW'(WPORT);
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign head_index_o = mem_q[rd_ptr_q][INDEX+1:2];
    assign head_op_o    = mem_q[rd_ptr_q][1:0];
    assign do_pop       = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        n_push   = '0;
        slot     = wr_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ready_o) begin
                // Lanes are packed densely in lane order; NOP and invalid lanes leave no hole.
                for (int n = 0; n < WPORT; n++) begin
                    if (push_valid_i[n] && (cti_op_t'(push_op_i[n*2 +: 2]) != CTI_NOP)) begin
                        slot        = wr_ptr_q + n_push[PW-1:0];
                        mem_d[slot] = {push_index_i[n*INDEX +: INDEX], push_op_i[n*2 +: 2]};
                        n_push      = n_push + CW'(1);
                    end
                end
            end
            wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            count_d  = count_q + n_push - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cti_counter_updater.sv
// rtl/cti_counter_updater.sv - queued read-modify-write engine owning the CTI counter RAM
module cti_counter_updater
    import cti_pkg::*;
#(
    parameter int WPORT  = CTI_FETCH_WIDTH,
    parameter int DEPTH  = 16,
    parameter int INDEX  = $clog2(DEPTH),
    parameter int WIDTH  = 8,
    parameter int QDEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WPORT-1:0]         req_valid_i,
    input  logic [WPORT*INDEX-1:0]   req_index_i,
    input  logic [WPORT*2-1:0]       req_op_i,
    output logic                     req_ready_o,
    input  logic                     flush_i,
    output logic [INDEX-1:0]         ram_rd_addr_o,
    input  logic [WIDTH-1:0]         ram_rd_data_i,
    output logic [INDEX-1:0]         ram_wr_addr_o,
    output logic [WIDTH-1:0]         ram_wr_data_o,
    output logic                     ram_we_o,
    output logic                     sat_o,
    output logic [$clog2(QDEPTH):0]  count_o,
    output logic                     busy_o
);

    localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}};

    logic [INDEX-1:0] head_index;
    logic [1:0]       head_op;
    logic             q_empty;
    logic             s1_valid;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             sat;

    logic [INDEX-1:0] rd_addr_q, rd_addr_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_sat_q, s2_sat_d;
    logic [INDEX-1:0] s2_addr_q, s2_addr_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    // A flush cancels this cycle's pop so nothing reaches stage 2 afterwards.
    assign s1_valid = !q_empty && !flush_i;

    cti_req_fifo #(
        .WPORT  (WPORT),
        .INDEX  (INDEX),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (req_valid_i),
        .push_index_i (req_index_i),
        .push_op_i    (req_op_i),
        .pop_i        (s1_valid),
        .flush_i      (flush_i),
        .head_index_o (head_index),
        .head_op_o    (head_op),
        .empty_o      (q_empty),
        .ready_o      (req_ready_o),
        .count_o      (count_o)
    );

    always_comb begin
        rd_addr_d = q_empty ? rd_addr_q : head_index;
        // The RAM has not yet absorbed the stage-2 write, so take the value from stage 2.
        operand   = (s2_valid_q && (s2_addr_q == rd_addr_d)) ? s2_data_q : ram_rd_data_i;
        result    = operand;
        sat       = 1'b0;
        case (cti_op_t'(head_op))
            CTI_INC: begin
                if (operand == SAT_MAX) sat = 1'b1;
                else                    result = operand + WIDTH'(1);
            end
            CTI_DEC: begin
                if (operand == '0) sat = 1'b1;
                else               result = operand - WIDTH'(1);
            end
            CTI_CLR: result = '0;
            default: result = operand;
        endcase
        s2_valid_d = s1_valid;
        s2_sat_d   = s1_valid && sat;
        s2_addr_d  = s1_valid ? rd_addr_d : s2_addr_q;
        s2_data_d  = s1_valid ? result    : s2_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_sat_q   <= s2_sat_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign ram_rd_addr_o = rd_addr_d;
    assign ram_wr_addr_o = s2_addr_q;
    assign ram_wr_data_o = s2_data_q;
    assign ram_we_o      = s2_valid_q;
    assign sat_o         = s2_sat_q;
    assign busy_o        = !q_empty || s2_valid_q;

endmodule

// File: tb/tb_cti_counter_updater.sv
// tb/tb_cti_counter_updater.sv - directed self-checking bench for cti_counter_updater
module tb_cti_counter_updater;
    import cti_pkg::*;

    localparam int WPORT  = 4;
    localparam int DEPTH  = 16;
    localparam int INDEX  = 4;
    localparam int WIDTH  = 8;
    localparam int QDEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WPORT-1:0]       req_valid;
    logic [WPORT*INDEX-1:0] req_index;
    logic [WPORT*2-1:0]     req_op;
    logic                   req_ready;
    logic                   flush;
    logic [INDEX-1:0]       rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic [INDEX-1:0]       wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   we;
    logic                   sat;
    logic [3:0]             count;
    logic                   busy;

    logic [WIDTH-1:0] ram [DEPTH];
    logic             pre_en;
    logic [INDEX-1:0] pre_addr;
    logic [WIDTH-1:0] pre_data;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    cti_counter_updater #(
        .WPORT(WPORT), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .QDEPTH(QDEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_index_i   (req_index),
        .req_op_i      (req_op),
        .req_ready_o   (req_ready),
        .flush_i       (flush),
        .ram_rd_addr_o (rd_addr),
        .ram_rd_data_i (rd_data),
        .ram_wr_addr_o (wr_addr),
        .ram_wr_data_o (wr_data),
        .ram_we_o      (we),
        .sat_o         (sat),
        .count_o       (count),
        .busy_o        (busy)
    );

    assign rd_data = ram[rd_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            if (we)     ram[wr_addr]  <= wr_data;
            if (pre_en) ram[pre_addr] <= pre_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_index = '0;
        req_op    = '0;
    endtask

    task automatic put(input int lane, input logic [INDEX-1:0] idx, input cti_op_t op);
        req_valid[lane]               = 1'b1;
        req_index[lane*INDEX +: INDEX] = idx;
        req_op[lane*2 +: 2]           = op;
    endtask

    task automatic put_all(input logic [INDEX-1:0] idx, input cti_op_t op);
        for (int l = 0; l < WPORT; l++) put(l, idx, op);
    endtask

    task automatic preload(input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        chk("idle_within_budget", busy, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        clear_req();
        step(); step();
        chk("rst_ready", req_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b0;

        // single INC to index 3
        put(0, 3, CTI_INC);
        step(); clear_req();
        chk("t1_count", count, 1);
        chk("t1_rd_addr", rd_addr, 3);
        chk("t1_we_early", we, 0);
        step();
        chk("t1_we", we, 1);
        chk("t1_wr_addr", wr_addr, 3);
        chk("t1_wr_data", wr_data, 1);
        chk("t1_sat", sat, 0);
        step();
        chk("t1_busy_low", busy, 0);
        chk("t1_we_low", we, 0);
        chk("t1_ram3", ram[3], 1);
        chk("t1_rd_addr_hold", rd_addr, 3);

        // four INCs to one index rely on forwarding
        put_all(5, CTI_INC);
        step(); clear_req();
        step();
        for (int k = 1; k <= WPORT; k++) begin
            chk("fwd_we", we, 1);
            chk("fwd_addr", wr_addr, 5);
            chk($sformatf("fwd_data%0d", k), wr_data, k);
            step();
        end
        chk("fwd_ram5", ram[5], 4);
        chk("fwd_idle", busy, 0);

        // saturation at both ends
        preload(7, 8'd255);
        put(0, 7, CTI_INC);
        put(1, 2, CTI_DEC);
        step(); clear_req();
        step();
        chk("sat_inc_addr", wr_addr, 7);
        chk("sat_inc_data", wr_data, 255);
        chk("sat_inc_pulse", sat, 1);
        step();
        chk("sat_dec_addr", wr_addr, 2);
        chk("sat_dec_data", wr_data, 0);
        chk("sat_dec_pulse", sat, 1);
        step();
        chk("sat_clear", sat, 0);

        // NOP lanes are compacted away; CLR zeroes
        preload(4, 8'd9);
        put(0, 4, CTI_NOP);
        put(1, 4, CTI_INC);
        put(2, 4, CTI_NOP);
        put(3, 4, CTI_CLR);
        step(); clear_req();
        chk("cmp_count", count, 2);
        step();
        chk("cmp_inc_data", wr_data, 10);
        step();
        chk("cmp_clr_data", wr_data, 0);
        chk("cmp_clr_addr", wr_addr, 4);
        step();
        chk("cmp_ram4", ram[4], 0);

        // fill until ready drops; held bundle taken once
        put_all(8, CTI_INC);
        step();
        chk("fill_count4", count, 4);
        chk("fill_ready4", req_ready, 1);
        clear_req(); put_all(8, CTI_INC);
        step();
        chk("fill_count7", count, 7);
        chk("fill_ready7", req_ready, 0);
        clear_req(); put_all(9, CTI_INC);
        step();
        chk("fill_count6", count, 6);
        chk("fill_ready6", req_ready, 0);
        step();
        chk("fill_count5", count, 5);
        chk("fill_ready5", req_ready, 0);
        step();
        chk("fill_count_back4", count, 4);
        chk("fill_ready_back", req_ready, 1);
        step(); clear_req();
        chk("fill_count_after", count, 7);
        wait_idle(40);
        chk("fill_ram8", ram[8], 8);
        chk("fill_ram9", ram[9], 4);

        // flush with 6 queued and a stage-2 write pending
        put_all(10, CTI_INC);
        step();
        clear_req(); put_all(11, CTI_INC);
        step(); clear_req();
        chk("fl_count7", count, 7);
        step();
        chk("fl_count6", count, 6);
        chk("fl_we", we, 1);
        chk("fl_wr_addr", wr_addr, 10);
        chk("fl_wr_data", wr_data, 2);
        flush = 1'b1;
        put_all(12, CTI_INC);
        step();
        flush = 1'b0; clear_req();
        chk("fl_count0", count, 0);
        chk("fl_no_we", we, 0);
        step();
        chk("fl_busy", busy, 0);
        chk("fl_no_we2", we, 0);
        chk("fl_ram10", ram[10], 2);
        chk("fl_ram11", ram[11], 0);
        chk("fl_ram12", ram[12], 0);

        // bundle dropped by flush while ready is high
        chk("fl2_ready", req_ready, 1);
        flush = 1'b1;
        put(0, 13, CTI_INC);
        step();
        flush = 1'b0; clear_req();
        chk("fl2_count", count, 0);
        step();
        chk("fl2_no_we", we, 0);
        chk("fl2_ram13", ram[13], 0);

        // reset in the middle of a drain
        put_all(14, CTI_INC);
        step(); clear_req();
        step();
        chk("rst_mid_we_before", we, 1);
        reset = 1'b1;
        step();
        chk("rst_mid_we", we, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_busy", busy, 0);
        reset = 1'b0;
        step();
        chk("rst_mid_we_after", we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
